// File: rtl/spatz_xif_offloader.sv
// Core-side X-interface initiator. It takes offload requests from the scalar
// pipeline and issues them to Spatz with a unique ID. It tracks writeback IDs
// in a small scoreboard and returns results to the core register-file port.
module spatz_xif_offloader #(
  parameter int unsigned NrOutstanding = 4,
  parameter int unsigned IdWidth       = $clog2(NrOutstanding),
  parameter int unsigned XLEN          = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // core request side
  input  logic                 core_valid_i,
  output logic                 core_ready_o,
  input  logic [31:0]          core_instr_i,
  input  logic [XLEN-1:0]      core_rs1_i,
  input  logic [XLEN-1:0]      core_rs2_i,
  input  logic [4:0]           core_rd_i,
  output logic                 core_rsp_valid_o,
  output logic                 core_rsp_illegal_o,
  // X-interface issue
  output logic                 x_issue_valid_o,
  input  logic                 x_issue_ready_i,
  output logic [31:0]          x_issue_instr_o,
  output logic [2*XLEN-1:0]    x_issue_rs_o,
  output logic [1:0]           x_issue_rs_valid_o,
  output logic [IdWidth-1:0]   x_issue_id_o,
  input  logic                 x_issue_resp_accept_i,
  input  logic                 x_issue_resp_writeback_i,
  input  logic                 x_issue_resp_exc_i,
  input  logic                 x_issue_resp_loadstore_i,
  // X-interface result
  input  logic                 x_result_valid_i,
  output logic                 x_result_ready_o,
  input  logic [IdWidth-1:0]   x_result_id_i,
  input  logic [XLEN-1:0]      x_result_data_i,
  input  logic                 x_result_we_i,
  input  logic                 x_result_exc_i,
  // register-file writeback
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [4:0]           wb_rd_o,
  output logic [XLEN-1:0]      wb_data_o,
  // status
  output logic                 exc_o,
  output logic                 spurious_o,
  output logic                 busy_o
);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              instr_q, instr_d;
  logic [XLEN-1:0]          rs1_q, rs1_d, rs2_q, rs2_d;
  logic [4:0]               rd_q, rd_d;
  logic [IdWidth-1:0]       id_q, id_d;
  logic [NrOutstanding-1:0] sb_valid_q, sb_valid_d;
  logic [4:0]               sb_rd_q [NrOutstanding];
  logic [4:0]               sb_rd_d [NrOutstanding];
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_illegal_q, rsp_illegal_d;
  logic                     exc_q, exc_d;
  logic                     spurious_q, spurious_d;
  logic                     wb_valid_q, wb_valid_d;
  logic [4:0]               wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]          wb_data_q, wb_data_d;

  logic                     free_found;
  logic [IdWidth-1:0]       free_id;
  logic                     core_ready, issue_hs, res_ready, res_hs;
  logic                     res_bypass, res_hit;
  logic [4:0]               res_rd;

  // The load/store hint has no consumer on this side of the interface.
  logic unused_loadstore;
  assign unused_loadstore = x_issue_resp_loadstore_i;

  // Lowest free ID, taken from the registered scoreboard so an entry freed
  // this cycle only becomes allocatable on the next one.
  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = int'(NrOutstanding) - 1; i >= 0; i--) begin
      if (!sb_valid_q[i]) begin
        free_found = 1'b1;
        free_id    = IdWidth'(i);
      end
    end
  end

  // Handshakes; ready outputs are forced low while reset is applied.
  assign core_ready = !rst_i && (state_q == IDLE) && core_valid_i && free_found;
  assign issue_hs   = (state_q == ISSUE) && x_issue_ready_i;
  assign res_ready  = !rst_i && (!wb_valid_q || wb_ready_i);
  assign res_hs     = x_result_valid_i && res_ready;
  // A result racing its own issue handshake uses the in-flight rd directly.
  assign res_bypass = res_hs && issue_hs && (x_result_id_i == id_q);
  assign res_hit    = res_bypass || sb_valid_q[x_result_id_i];
  assign res_rd     = res_bypass ? rd_q : sb_rd_q[x_result_id_i];

  // Next-state logic for the issue FSM, scoreboard and writeback register.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    state_d       = state_q;
    instr_d       = instr_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    id_d          = id_q;
    sb_valid_d    = sb_valid_q;
    sb_rd_d       = sb_rd_q;
    rsp_valid_d   = 1'b0;
    rsp_illegal_d = 1'b0;
    exc_d         = 1'b0;
    spurious_d    = 1'b0;
    wb_valid_d    = wb_valid_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;

    if (wb_ready_i) wb_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (core_ready) begin
          instr_d = core_instr_i;
          rs1_d   = core_rs1_i;
          rs2_d   = core_rs2_i;
          rd_d    = core_rd_i;
          id_d    = free_id;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_hs) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_illegal_d = !x_issue_resp_accept_i;
          if (x_issue_resp_exc_i) exc_d = 1'b1;
          if (x_issue_resp_accept_i && x_issue_resp_writeback_i && !res_bypass) begin
            sb_valid_d[id_q] = 1'b1;
            sb_rd_d[id_q]    = rd_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (res_hs) begin
      if (res_hit) begin
        if (!res_bypass) sb_valid_d[x_result_id_i] = 1'b0;
        if (x_result_we_i) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = res_rd;
          wb_data_d  = x_result_data_i;
        end
        if (x_result_exc_i) exc_d = 1'b1;
      end else begin
        spurious_d = 1'b1;
      end
    end
  end

  // State and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      id_q          <= '0;
      sb_valid_q    <= '0;
      // NOTE: the scoreboard is a handful of flops, not a RAM, so it is reset
      // like any other register.
      for (int i = 0; i < int'(NrOutstanding); i++) sb_rd_q[i] <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      exc_q         <= 1'b0;
      spurious_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      instr_q       <= instr_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      id_q          <= id_d;
      sb_valid_q    <= sb_valid_d;
      sb_rd_q       <= sb_rd_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_illegal_q <= rsp_illegal_d;
      exc_q         <= exc_d;
      spurious_q    <= spurious_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
    end
  end

  assign core_ready_o       = core_ready;
  assign core_rsp_valid_o   = rsp_valid_q;
  assign core_rsp_illegal_o = rsp_illegal_q;
  assign x_issue_valid_o    = (state_q == ISSUE);
  assign x_issue_instr_o    = instr_q;
  assign x_issue_rs_o       = {rs2_q, rs1_q};
  assign x_issue_rs_valid_o = {2{state_q == ISSUE}};
  assign x_issue_id_o       = id_q;
  assign x_result_ready_o   = res_ready;
  assign wb_valid_o         = wb_valid_q;
  assign wb_rd_o            = wb_rd_q;
  assign wb_data_o          = wb_data_q;
  assign exc_o              = exc_q;
  assign spurious_o         = spurious_q;
  assign busy_o             = (state_q == ISSUE) || (|sb_valid_q) || wb_valid_q;

endmodule

// File: tb/tb_spatz_xif_offloader.sv
// Directed bench for spatz_xif_offloader: stimulus pushes expected issue,
// response and writeback records into queues; a negedge monitor pops and
// compares them whenever the DUT presents the matching handshake.
module tb_spatz_xif_offloader;

  localparam int IdW = 2;

  logic clk_i = 1'b0;
  logic rst_i;
  logic core_valid_i, core_ready_o;
  logic [31:0] core_instr_i, core_rs1_i, core_rs2_i;
  logic [4:0] core_rd_i;
  logic core_rsp_valid_o, core_rsp_illegal_o;
  logic x_issue_valid_o, x_issue_ready_i;
  logic [31:0] x_issue_instr_o;
  logic [63:0] x_issue_rs_o;
  logic [1:0] x_issue_rs_valid_o;
  logic [IdW-1:0] x_issue_id_o;
  logic x_issue_resp_accept_i, x_issue_resp_writeback_i, x_issue_resp_exc_i, x_issue_resp_loadstore_i;
  logic x_result_valid_i, x_result_ready_o;
  logic [IdW-1:0] x_result_id_i;
  logic [31:0] x_result_data_i;
  logic x_result_we_i, x_result_exc_i;
  logic wb_valid_o, wb_ready_i;
  logic [4:0] wb_rd_o;
  logic [31:0] wb_data_o;
  logic exc_o, spurious_o, busy_o;

  spatz_xif_offloader #(.NrOutstanding(4), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
    .core_instr_i(core_instr_i), .core_rs1_i(core_rs1_i), .core_rs2_i(core_rs2_i),
    .core_rd_i(core_rd_i),
    .core_rsp_valid_o(core_rsp_valid_o), .core_rsp_illegal_o(core_rsp_illegal_o),
    .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
    .x_issue_instr_o(x_issue_instr_o), .x_issue_rs_o(x_issue_rs_o),
    .x_issue_rs_valid_o(x_issue_rs_valid_o), .x_issue_id_o(x_issue_id_o),
    .x_issue_resp_accept_i(x_issue_resp_accept_i),
    .x_issue_resp_writeback_i(x_issue_resp_writeback_i),
    .x_issue_resp_exc_i(x_issue_resp_exc_i),
    .x_issue_resp_loadstore_i(x_issue_resp_loadstore_i),
    .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
    .x_result_id_i(x_result_id_i), .x_result_data_i(x_result_data_i),
    .x_result_we_i(x_result_we_i), .x_result_exc_i(x_result_exc_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .exc_o(exc_o), .spurious_o(spurious_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [IdW-1:0] id; logic [31:0] instr; } iss_t;
  typedef struct packed { logic illegal; logic exc; } rsp_t;
  typedef struct packed { logic [4:0] rd; logic [31:0] data; } wb_t;

  iss_t exp_iss_q[$];
  rsp_t exp_rsp_q[$];
  wb_t  exp_wb_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int spur_cnt = 0;
  int exc_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: DUT produced an output with no expectation queued at %0t", name, $time);
  endtask

  // Monitor: compares every handshake against the head of its queue.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (x_issue_valid_o && x_issue_ready_i) begin
        if (exp_iss_q.size() == 0) unexpected("issue");
        else begin
          iss_t e;
          e = exp_iss_q.pop_front();
          check("issue_id", 64'(x_issue_id_o), 64'(e.id));
          check("issue_instr", 64'(x_issue_instr_o), 64'(e.instr));
          check("issue_rs_valid", 64'(x_issue_rs_valid_o), 64'(2'b11));
        end
      end
      if (core_rsp_valid_o) begin
        if (exp_rsp_q.size() == 0) unexpected("rsp");
        else begin
          rsp_t e;
          e = exp_rsp_q.pop_front();
          check("rsp_illegal", 64'(core_rsp_illegal_o), 64'(e.illegal));
          check("rsp_exc", 64'(exc_o), 64'(e.exc));
        end
      end
      if (wb_valid_o && wb_ready_i) begin
        if (exp_wb_q.size() == 0) unexpected("wb");
        else begin
          wb_t e;
          e = exp_wb_q.pop_front();
          check("wb_rd", 64'(wb_rd_o), 64'(e.rd));
          check("wb_data", 64'(wb_data_o), 64'(e.data));
        end
      end
      if (spurious_o) spur_cnt++;
      if (exc_o) exc_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic core_req(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [4:0] rd, input logic [IdW-1:0] exp_id);
    bit got = 1'b0;
    core_valid_i = 1'b1; core_instr_i = instr; core_rs1_i = rs1; core_rs2_i = rs2; core_rd_i = rd;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (core_ready_o) begin got = 1'b1; break; end
    end
    check("core_ready_wait", 64'(got), 64'd1);
    if (got) exp_iss_q.push_back('{id: exp_id, instr: instr});
    @(posedge clk_i); #1;
    core_valid_i = 1'b0;
  endtask

  task automatic issue_resp(input logic accept, input logic wb, input logic exc);
    bit got = 1'b0;
    x_issue_ready_i = 1'b1;
    x_issue_resp_accept_i = accept; x_issue_resp_writeback_i = wb; x_issue_resp_exc_i = exc;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (x_issue_valid_o) begin got = 1'b1; break; end
    end
    check("issue_valid_wait", 64'(got), 64'd1);
    if (got) exp_rsp_q.push_back('{illegal: !accept, exc: exc});
    @(posedge clk_i); #1;
    x_issue_ready_i = 1'b0;
    x_issue_resp_accept_i = 1'b0; x_issue_resp_writeback_i = 1'b0; x_issue_resp_exc_i = 1'b0;
    x_result_valid_i = 1'b0;
  endtask

  task automatic result(input logic [IdW-1:0] id, input logic [31:0] data, input logic we, input logic exc);
    bit got = 1'b0;
    x_result_valid_i = 1'b1; x_result_id_i = id; x_result_data_i = data;
    x_result_we_i = we; x_result_exc_i = exc;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (x_result_ready_o) begin got = 1'b1; break; end
    end
    check("result_ready_wait", 64'(got), 64'd1);
    @(posedge clk_i); #1;
    x_result_valid_i = 1'b0; x_result_we_i = 1'b0; x_result_exc_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_core_ready"}, 64'(core_ready_o), 64'd0);
    check({tag, "_rsp_valid"}, 64'(core_rsp_valid_o), 64'd0);
    check({tag, "_issue_valid"}, 64'(x_issue_valid_o), 64'd0);
    check({tag, "_issue_id"}, 64'(x_issue_id_o), 64'd0);
    check({tag, "_rs_valid"}, 64'(x_issue_rs_valid_o), 64'd0);
    check({tag, "_result_ready"}, 64'(x_result_ready_o), 64'd0);
    check({tag, "_wb_valid"}, 64'(wb_valid_o), 64'd0);
    check({tag, "_exc"}, 64'(exc_o), 64'd0);
    check({tag, "_spurious"}, 64'(spurious_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    core_valid_i = 1'b0; core_instr_i = '0; core_rs1_i = '0; core_rs2_i = '0; core_rd_i = '0;
    x_issue_ready_i = 1'b0; x_issue_resp_accept_i = 1'b0; x_issue_resp_writeback_i = 1'b0;
    x_issue_resp_exc_i = 1'b0; x_issue_resp_loadstore_i = 1'b0;
    x_result_valid_i = 1'b0; x_result_id_i = '0; x_result_data_i = '0;
    x_result_we_i = 1'b0; x_result_exc_i = 1'b0;
    wb_ready_i = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // vsetvli: ID 0, result bypassed in the issue handshake cycle.
    core_req(32'h0c00_7057, 32'd8, 32'd0, 5'd5, 2'd0);
    x_result_valid_i = 1'b1; x_result_id_i = 2'd0; x_result_data_i = 32'h10;
    x_result_we_i = 1'b1; x_result_exc_i = 1'b0;
    exp_wb_q.push_back('{rd: 5'd5, data: 32'h10});
    issue_resp(1'b1, 1'b1, 1'b0);
    x_result_we_i = 1'b0;
    idle(1);
    @(negedge clk_i);
    check("bypass_busy_after", 64'(busy_o), 64'd0);
    @(posedge clk_i); #1;

    // Fill all four IDs with writeback-accepted issues.
    for (int i = 0; i < 4; i++) begin
      core_req(32'h1000_0000 + 32'(i), 32'(i), 32'(i + 16), 5'(i + 1), IdW'(i));
      issue_resp(1'b1, 1'b1, 1'b0);
    end
    core_valid_i = 1'b1; core_instr_i = 32'h5555_0005; core_rd_i = 5'd6;
    @(negedge clk_i);
    check("full_core_ready", 64'(core_ready_o), 64'd0);
    check("full_busy", 64'(busy_o), 64'd1);
    @(posedge clk_i); #1;
    x_result_valid_i = 1'b1; x_result_id_i = 2'd2; x_result_data_i = 32'h22;
    x_result_we_i = 1'b1; x_result_exc_i = 1'b0;
    exp_wb_q.push_back('{rd: 5'd3, data: 32'h22});
    @(negedge clk_i);
    check("free_same_cycle_ready", 64'(core_ready_o), 64'd0);
    check("full_result_ready", 64'(x_result_ready_o), 64'd1);
    @(posedge clk_i); #1;
    x_result_valid_i = 1'b0; x_result_we_i = 1'b0;
    core_req(32'h5555_0005, 32'd0, 32'd0, 5'd6, 2'd2);
    issue_resp(1'b1, 1'b1, 1'b0);
    // Scoreboard: id0 rd1, id1 rd2, id2 rd6, id3 rd4.

    // Result stalled behind a blocked writeback, then back-to-back results.
    wb_ready_i = 1'b0;
    exp_wb_q.push_back('{rd: 5'd1, data: 32'hA0});
    result(2'd0, 32'hA0, 1'b1, 1'b0);
    x_result_valid_i = 1'b1; x_result_id_i = 2'd1; x_result_data_i = 32'hA1; x_result_we_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("stall_result_ready", 64'(x_result_ready_o), 64'd0);
      check("stall_wb_valid", 64'(wb_valid_o), 64'd1);
      check("stall_wb_rd", 64'(wb_rd_o), 64'd1);
      check("stall_wb_data", 64'(wb_data_o), 64'hA0);
      @(posedge clk_i); #1;
    end
    wb_ready_i = 1'b1;
    exp_wb_q.push_back('{rd: 5'd2, data: 32'hA1});
    result(2'd1, 32'hA1, 1'b1, 1'b0);
    exp_wb_q.push_back('{rd: 5'd4, data: 32'hA3});
    result(2'd3, 32'hA3, 1'b1, 1'b0);
    exp_wb_q.push_back('{rd: 5'd6, data: 32'hA2});
    result(2'd2, 32'hA2, 1'b1, 1'b0);
    idle(2);
    @(negedge clk_i);
    check("drained_busy", 64'(busy_o), 64'd0);
    @(posedge clk_i); #1;

    // Issue stall keeps fields stable, then rejection frees the ID.
    core_req(32'hDEAD_0057, 32'h11, 32'h22, 5'd7, 2'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("istall_valid", 64'(x_issue_valid_o), 64'd1);
      check("istall_instr", 64'(x_issue_instr_o), 64'hDEAD_0057);
      check("istall_id", 64'(x_issue_id_o), 64'd0);
      check("istall_rs", x_issue_rs_o, {32'h22, 32'h11});
    end
    @(posedge clk_i); #1;
    issue_resp(1'b0, 1'b0, 1'b0);
    core_req(32'hBEEF_0057, 32'h1, 32'h2, 5'd8, 2'd0);
    issue_resp(1'b1, 1'b0, 1'b0);

    // Spurious result and exception pulses.
    result(2'd1, 32'hBAD, 1'b1, 1'b0);
    core_req(32'h0000_1157, 32'd0, 32'd0, 5'd9, 2'd0);
    issue_resp(1'b1, 1'b1, 1'b0);
    result(2'd0, 32'h5, 1'b0, 1'b1);
    core_req(32'h0000_2257, 32'd0, 32'd0, 5'd12, 2'd0);
    issue_resp(1'b1, 1'b0, 1'b1);
    idle(3);
    check("spurious_pulses", 64'(spur_cnt), 64'd1);
    check("exc_pulses", 64'(exc_cnt), 64'd2);
    check("exc_busy", 64'(busy_o), 64'd0);

    // Reset while in ISSUE with two IDs outstanding.
    core_req(32'h0A0A_0057, 32'd0, 32'd0, 5'd10, 2'd0);
    issue_resp(1'b1, 1'b1, 1'b0);
    core_req(32'h0B0B_0057, 32'd0, 32'd0, 5'd11, 2'd1);
    issue_resp(1'b1, 1'b1, 1'b0);
    core_req(32'h0C0C_0057, 32'd0, 32'd0, 5'd13, 2'd2);
    @(negedge clk_i);
    check("pre_reset_issue_valid", 64'(x_issue_valid_o), 64'd1);
    check("pre_reset_busy", 64'(busy_o), 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_iss_q.delete();
    core_req(32'h0D0D_0057, 32'd0, 32'd0, 5'd14, 2'd0);
    issue_resp(1'b1, 1'b0, 1'b0);
    idle(3);

    check("left_issue", 64'(exp_iss_q.size()), 64'd0);
    check("left_rsp", 64'(exp_rsp_q.size()), 64'd0);
    check("left_wb", 64'(exp_wb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
